// File: rtl/dff_pkg.sv
// Shared control-level constants used by every block that ties off clr/stall
// or drives active-low strobes.
package dff_pkg;

    localparam logic ENABLE    = 1'b1;
    localparam logic DISABLE   = 1'b0;
    localparam logic ENABLE_N  = 1'b0;
    localparam logic DISABLE_N = 1'b1;

endpackage : dff_pkg

// File: rtl/dff.sv
// Parameterised D-type pipeline register with synchronous reset, clear and hold.
// rst and clr both load RESET_VALUE; they stay separate so global reset and local flush are independent.
module dff
    import dff_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  stall,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst == ENABLE || clr == ENABLE) begin
            q <= RESET_VALUE;
        end else if (stall == DISABLE) begin
            q <= d;
        end
    end

endmodule : dff

// File: tb/tb_dff.sv
// Scoreboard bench for dff: three instances (default, 1-bit idle-high, 8-bit with reset value 8'h80).
module tb_dff;
    import dff_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr8, stall8;
    logic [7:0] d8, q8;
    logic       d_def, q_def;
    logic       d_one, q_one;

    logic [7:0] sb_def[$];
    logic [7:0] sb_one[$];
    logic [7:0] sb8[$];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    dff u_def (
        .clk(clk), .rst(rst), .clr(DISABLE), .stall(DISABLE), .d(d_def), .q(q_def)
    );

    dff #(1, 1'b1) u_one (
        .clk(clk), .rst(rst), .clr(DISABLE), .stall(DISABLE), .d(d_one), .q(q_one)
    );

    dff #(8, 8'h80) u_byte (
        .clk(clk), .rst(rst), .clr(clr8), .stall(stall8), .d(d8), .q(q8)
    );

    task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic pop_check(input string tag, input logic [7:0] actual, inout logic [7:0] sb[$]);
        if (sb.size() > 0) check(tag, actual, sb.pop_front());
    endtask

    // Drive one cycle of stimulus, record expectations, then compare after the edge.
    task automatic step(input logic r, input logic c, input logic s, input logic [7:0] dv8,
                        input logic dd, input logic d1,
                        input logic [7:0] e8, input logic ed, input logic e1);
        rst    = r;
        clr8   = c;
        stall8 = s;
        d8     = dv8;
        d_def  = dd;
        d_one  = d1;
        sb8.push_back(e8);
        sb_def.push_back({7'b0, ed});
        sb_one.push_back({7'b0, e1});
        @(posedge clk);
        #1;
        pop_check("byte", q8, sb8);
        pop_check("def", {7'b0, q_def}, sb_def);
        pop_check("one", {7'b0, q_one}, sb_one);
    endtask

    initial begin
        @(negedge clk);
        // Reset held for two edges: default -> 0, idle-high -> 1, byte -> 8'h80.
        step(1, 0, 0, 8'h7E, 1, 0, 8'h80, 0, 1);
        step(1, 0, 0, 8'h7E, 1, 0, 8'h80, 0, 1);

        // Delay line on the byte instance; handshake pattern 1,0,0,1 on the idle-high one.
        step(0, 0, 0, 8'h00, 0, 1, 8'h00, 0, 1);
        step(0, 0, 0, 8'hA5, 1, 0, 8'hA5, 1, 0);
        step(0, 0, 0, 8'hFF, 1, 0, 8'hFF, 1, 0);
        step(0, 0, 0, 8'h3C, 0, 1, 8'h3C, 0, 1);

        // Stall for three edges, then release captures the current d only.
        step(0, 0, 0, 8'h11, 1, 1, 8'h11, 1, 1);
        step(0, 0, 1, 8'h22, 0, 0, 8'h11, 0, 0);
        step(0, 0, 1, 8'h33, 1, 1, 8'h11, 1, 1);
        step(0, 0, 1, 8'h44, 0, 0, 8'h11, 0, 0);
        step(0, 0, 0, 8'h55, 1, 1, 8'h55, 1, 1);

        // Clear beats stall.
        step(0, 0, 0, 8'h12, 0, 0, 8'h12, 0, 0);
        step(0, 1, 1, 8'h34, 0, 0, 8'h80, 0, 0);

        // Reset beats stall; first edge after release captures d.
        step(0, 0, 0, 8'h5A, 1, 0, 8'h5A, 1, 0);
        step(1, 0, 1, 8'h7E, 1, 0, 8'h80, 0, 1);
        step(0, 0, 0, 8'h7E, 1, 0, 8'h7E, 1, 0);

        // Clear alone, reset together with clear, then normal capture resumes.
        step(0, 1, 0, 8'hAA, 0, 1, 8'h80, 0, 1);
        step(0, 0, 0, 8'h01, 1, 1, 8'h01, 1, 1);
        step(1, 1, 0, 8'hC3, 1, 0, 8'h80, 0, 1);
        step(0, 0, 0, 8'hC3, 1, 0, 8'hC3, 1, 0);

        // Random plain-delay tail: expected is simply the value driven this cycle.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] r8;
            logic       rd, r1;
            r8 = 8'($urandom_range(0, 255));
            rd = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            step(0, 0, 0, r8, rd, r1, r8, rd, r1);
        end

        if (sb8.size() != 0 || sb_def.size() != 0 || sb_one.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0",
                     sb8.size() + sb_def.size() + sb_one.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_dff

// File: doc/dff.md
# dff

Parameterised D-type pipeline register: the generic storage element used across the SoC. Control blocks such as the FT232H bridge controller use it to delay handshake signals by one clock. It captures `d` on every rising clock edge unless held or cleared, and provides a per-instance reset value so that active-low strobes can idle high.

## Interface
Parameters (positional order is fixed: width first, reset value second):
- `DATA_WIDTH`, default 1: width of `d` and `q`; legal values ≥ 1.
- `RESET_VALUE`, default all-zeros (`DATA_WIDTH'b0`): value loaded into `q` by reset and by clear.

Ports (positional order is fixed exactly as listed):
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst`  in  1: one clock; reset is synchronous and active-high. Loads `RESET_VALUE`.
- `clr`  in  1: synchronous clear, active-high (`ENABLE`). Loads `RESET_VALUE`.
- `stall`  in  1: hold, active-high (`ENABLE`). When asserted, `q` keeps its value.
- `d`  in  DATA_WIDTH: next-state data.
- `q`  out  DATA_WIDTH: registered output.

## Operation
- The block is a single register with no other state. `q` is the register itself, with no combinational path from any input to `q`.
- Priority at each rising `clk` edge, highest first:
  - `rst`=1: `q` ← `RESET_VALUE`.
  - else `clr`=1: `q` ← `RESET_VALUE`.
  - else `stall`=1: `q` ← `q` (hold).
  - else: `q` ← `d`.
- With `clr`=`stall`=`DISABLE` (0), the block is a plain one-cycle delay. This is the mode used by handshake-delay instances.
- `RESET_VALUE` is applied bit-exact for any width. No sign extension or truncation occurs inside the block.
- `rst` and `clr` are functionally identical. They are kept separate so that a global reset and a local pipeline flush can be driven independently.

## Timing
- Latency: exactly 1 cycle from `d` to `q`.
- Reset:
  - `q` = `RESET_VALUE` from the first rising edge sampled with `rst`=1, and for as long as `rst` is held.
  - Before the first reset edge, `q` is undefined (X in simulation). The bench must not check it.
- Reset released mid-stream: the first edge with `rst`=0 captures `d` normally, or holds/clears per `stall`/`clr`.
- Simultaneous events:
  - `rst`=1 overrides `clr`/`stall`.
  - `clr`=1 overrides `stall`.
- Stall of any length holds `q` indefinitely. On release, the edge captures the current `d`; no queued history is kept.
- Inputs are sampled only at the rising edge. Glitches between edges have no effect.

## Structure
- Shared package/defines header, included by every block: `ENABLE`=1'b1, `DISABLE`=1'b0, `ENABLE_N`=1'b0, `DISABLE_N`=1'b1. Callers tie `clr`/`stall` with these names.
- No sub-modules; this is a leaf cell.
- A vector-array wrapper (`dff_array`) may be built from it later; it is out of scope here.

## Test plan
- Reset value, default parameters: hold `rst`=1 for 2 edges with `d`=1 → `q`=0. Repeat with `DATA_WIDTH`=1, `RESET_VALUE`=1'b1 and `d`=0 → `q`=1.
- Delay line: `DATA_WIDTH`=8, `clr`=`stall`=0, drive `d` = 8'h00, 8'hA5, 8'hFF, 8'h3C on consecutive edges → `q` shows the same sequence one cycle later, with exact values.
- Stall: `q`=8'h11. Assert `stall` for 3 edges while `d` = 8'h22, 8'h33, 8'h44 → `q` stays 8'h11. Deassert with `d`=8'h55 → `q`=8'h55 after the next edge.
- Clear priority: `RESET_VALUE`=8'h80, `q`=8'h12. Assert `clr`=1 and `stall`=1 together with `d`=8'h34 → `q`=8'h80 after one edge.
- Reset priority and release: assert `rst`=1, `clr`=0, `stall`=1, `d`=8'h7E → `q`=`RESET_VALUE`. Drop `rst` with `stall`=0 and `d`=8'h7E → `q`=8'h7E on the first edge after release.
- Handshake-delay use: 1-bit instance with `RESET_VALUE`=1. Toggle `d` 1→0→0→1 after reset → `q` = 1 (reset), then 1, 0, 0, 1 lagging `d` by exactly one cycle.
